// File: rtl/preempt_int_ctrl.sv
// Preemption/interrupt source for the time-sharing OS: emits a quantum-expiry or
// user-HALT pulse, latches cause and resume PC, then waits for the OS acknowledge.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | timer disarmed, watching for a user HALT
// S_COUNT  | quantum down-counter running (decrements on user cycles only)
// S_WAIT   | interrupt delivered, cause/PC latched, waiting for GetInterruption
module preempt_int_ctrl #(
   parameter int                 PC_W   = 11,
   parameter int                 TIME_W = 16,
   parameter logic [PC_W-1:0]    OS_END = 11'd256
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_halt,
   input  logic              i_set_clock,
   input  logic [TIME_W-1:0] i_int_time,
   input  logic [PC_W-1:0]   i_pc,
   input  logic              i_get_interruption,
   output logic              o_int_clk,
   output logic              o_int_halt,
   output logic [1:0]        o_cause,
   output logic [PC_W-1:0]   o_saved_pc,
   output logic              o_armed
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_QUANTUM = 2'd1;
   localparam logic [1:0] CAUSE_HALT    = 2'd2;

   logic [1:0]        r_state;
   logic [TIME_W-1:0] r_cnt;
   logic              r_int_clk;
   logic              r_int_halt;
   logic [1:0]        r_cause;
   logic [PC_W-1:0]   r_saved_pc;
   logic              r_armed;

   logic w_user;
   logic w_time_nz;
   logic w_halt_trap;
   logic w_dec;
   logic w_expire;

   assign w_user      = (i_pc >= OS_END);
   assign w_time_nz   = (i_int_time != '0);
   assign w_halt_trap = i_halt && w_user;
   // Reload and halt both take priority over the decrement on the same edge.
   assign w_dec       = (r_state == S_COUNT) && w_user && !i_set_clock &&
                        !w_halt_trap && (r_cnt != '0);
   assign w_expire    = w_dec && (r_cnt == {{(TIME_W-1){1'b0}}, 1'b1});

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_int_clk  <= 1'b0;
         r_int_halt <= 1'b0;
         r_cause    <= CAUSE_NONE;
         r_saved_pc <= '0;
         r_armed    <= 1'b0;
      end else begin
         r_int_clk  <= 1'b0;
         r_int_halt <= 1'b0;
         case (r_state)
            S_WAIT: begin
               if (i_get_interruption) begin
                  r_cause <= CAUSE_NONE;
                  if (i_set_clock && w_time_nz) begin
                     r_cnt   <= i_int_time;
                     r_armed <= 1'b1;
                     r_state <= S_COUNT;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               if (w_halt_trap) begin
                  r_int_halt <= 1'b1;
                  r_cause    <= CAUSE_HALT;
                  r_saved_pc <= i_pc;
                  r_armed    <= 1'b0;
                  r_state    <= S_WAIT;
               end else if (i_set_clock) begin
                  // A zero quantum disarms the timer.
                  if (w_time_nz) begin
                     r_cnt   <= i_int_time;
                     r_armed <= 1'b1;
                     r_state <= S_COUNT;
                  end else begin
                     r_cnt   <= '0;
                     r_armed <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else if (w_dec) begin
                  r_cnt <= r_cnt - 1'b1;
                  if (w_expire) begin
                     r_int_clk  <= 1'b1;
                     r_cause    <= CAUSE_QUANTUM;
                     r_saved_pc <= i_pc + 1'b1;
                     r_armed    <= 1'b0;
                     r_state    <= S_WAIT;
                  end
               end
            end
         endcase
      end
   end

   assign o_int_clk  = r_int_clk;
   assign o_int_halt = r_int_halt;
   assign o_cause    = r_cause;
   assign o_saved_pc = r_saved_pc;
   assign o_armed    = r_armed;

endmodule

// File: tb/tb_preempt_int_ctrl.sv
// Directed bench for preempt_int_ctrl: behavioural model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_preempt_int_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt = 1'b0;
   logic        set_clock = 1'b0;
   logic [15:0] int_time = '0;
   logic [10:0] pc = '0;
   logic        get_int = 1'b0;
   logic        int_clk;
   logic        int_halt;
   logic [1:0]  cause;
   logic [10:0] saved_pc;
   logic        armed;

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   preempt_int_ctrl dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_halt(halt),
      .i_set_clock(set_clock),
      .i_int_time(int_time),
      .i_pc(pc),
      .i_get_interruption(get_int),
      .o_int_clk(int_clk),
      .o_int_halt(int_halt),
      .o_cause(cause),
      .o_saved_pc(saved_pc),
      .o_armed(armed)
   );

   always #5 clk = ~clk;

   // Behavioural model: armed flag, user cycles left in the quantum, pending interrupt.
   bit          m_armed = 0;
   int          m_left = 0;
   bit          m_pending = 0;
   bit          e_int_clk = 0;
   bit          e_int_halt = 0;
   int          e_cause = 0;
   logic [10:0] e_saved = '0;

   always @(posedge clk) begin
      bit user;
      user = (int'(pc) >= 256);
      e_int_clk = 0;
      e_int_halt = 0;
      if (rst) begin
         m_armed = 0; m_left = 0; m_pending = 0; e_cause = 0; e_saved = '0;
      end else if (m_pending) begin
         if (get_int) begin
            m_pending = 0;
            e_cause = 0;
            if (set_clock && int_time != 0) begin
               m_armed = 1; m_left = int'(int_time);
            end
         end
      end else if (halt && user) begin
         e_int_halt = 1; e_cause = 2; e_saved = pc; m_armed = 0; m_pending = 1;
      end else if (set_clock) begin
         m_armed = (int_time != 0);
         m_left = int'(int_time);
      end else if (m_armed && user) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            e_int_clk = 1; e_cause = 1; e_saved = (pc + 11'd1) % 2048;
            m_armed = 0; m_pending = 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_int_clk", int'(int_clk), int'(e_int_clk));
         chk("model_int_halt", int'(int_halt), int'(e_int_halt));
         chk("model_cause", int'(cause), e_cause);
         chk("model_saved_pc", int'(saved_pc), int'(e_saved));
         chk("model_armed", int'(armed), int'(m_armed));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_clk(input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!int_clk && n < bound);
   endtask

   task automatic load(input int t, input int p);
      pc = 11'(p); int_time = 16'(t); set_clock = 1'b1;
      tick();
      set_clock = 1'b0;
   endtask

   task automatic ack();
      get_int = 1'b1;
      tick();
      get_int = 1'b0;
   endtask

   initial begin
      int n;
      bit saw;
      tick(); tick();
      rst = 1'b0;
      check_en = 1'b1;
      chk("reset_cause", int'(cause), 0);
      chk("reset_saved_pc", int'(saved_pc), 0);
      chk("reset_armed", int'(armed), 0);

      // Quantum 5 in user code.
      load(5, 300);
      chk("t1_armed", int'(armed), 1);
      wait_clk(20, n);
      chk("t1_latency", n, 5);
      chk("t1_cause", int'(cause), 1);
      chk("t1_saved_pc", int'(saved_pc), 301);
      chk("t1_armed_off", int'(armed), 0);
      tick();
      chk("t1_pulse_width", int'(int_clk), 0);
      ack();
      chk("t1_ack_cause", int'(cause), 0);

      // Counter holds in OS code.
      load(4, 100);
      saw = 0;
      repeat (10) begin tick(); if (int_clk) saw = 1; end
      chk("t2_no_os_expiry", int'(saw), 0);
      pc = 11'd300;
      wait_clk(20, n);
      chk("t2_latency", n, 4);
      ack();

      // Halt and expiry on the same edge: halt wins.
      load(2, 400);
      tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("t3_int_halt", int'(int_halt), 1);
      chk("t3_int_clk", int'(int_clk), 0);
      chk("t3_cause", int'(cause), 2);
      chk("t3_saved_pc", int'(saved_pc), 400);

      // WAIT_ACK ignores halts; ack plus reload re-arms.
      saw = 0;
      for (int i = 0; i < 20; i++) begin
         halt = (i % 2 == 0);
         tick();
         if (int_halt || int_clk) saw = 1;
      end
      halt = 1'b0;
      chk("t4_no_pulses", int'(saw), 0);
      chk("t4_cause_held", int'(cause), 2);
      get_int = 1'b1; set_clock = 1'b1; int_time = 16'd3;
      tick();
      get_int = 1'b0; set_clock = 1'b0;
      chk("t4_cause_clear", int'(cause), 0);
      chk("t4_rearmed", int'(armed), 1);
      wait_clk(20, n);
      chk("t4_latency", n, 3);
      ack();

      // Reset mid-count aborts; zero quantum does not arm.
      load(5, 300);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_int_clk", int'(int_clk), 0);
      chk("t5_rst_cause", int'(cause), 0);
      chk("t5_rst_saved_pc", int'(saved_pc), 0);
      chk("t5_rst_armed", int'(armed), 0);
      saw = 0;
      repeat (10) begin tick(); if (int_clk) saw = 1; end
      chk("t5_no_clk", int'(saw), 0);
      load(0, 300);
      chk("t5_zero_quantum", int'(armed), 0);

      // OS-region halt ignored in IDLE and COUNT.
      pc = 11'd10; halt = 1'b1;
      tick();
      chk("t6_idle_os_halt", int'(int_halt), 0);
      halt = 1'b0;
      load(3, 10);
      halt = 1'b1;
      saw = 0;
      repeat (3) begin tick(); if (int_halt) saw = 1; end
      halt = 1'b0;
      chk("t6_count_os_halt", int'(saw), 0);
      chk("t6_still_armed", int'(armed), 1);
      pc = 11'd300;
      wait_clk(20, n);
      chk("t6_latency", n, 3);
      ack();

      // PC boundary 255/256 and resume-PC wrap.
      load(2, 255);
      saw = 0;
      repeat (3) begin tick(); if (int_clk) saw = 1; end
      chk("t7_pc255_os", int'(saw), 0);
      pc = 11'd256;
      wait_clk(20, n);
      chk("t7_latency", n, 2);
      chk("t7_saved_pc", int'(saved_pc), 257);
      ack();
      load(1, 2047);
      wait_clk(20, n);
      chk("t8_latency", n, 1);
      chk("t8_saved_wrap", int'(saved_pc), 0);
      ack();
      tick();

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
